// File: rtl/md_pkg.sv
// ============================================================================
// md_pkg : shared encodings and defaults for the multiply/divide sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

package md_pkg;

   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;

   typedef enum logic [1:0] {
      MD_MULT  = 2'd0,
      MD_MULTU = 2'd1,
      MD_DIV   = 2'd2,
      MD_DIVU  = 2'd3
   } md_op_t;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } md_state_t;

   function automatic logic is_div(input md_op_t op);
      return op[1];
   endfunction

endpackage

`default_nettype wire

// File: rtl/md_arith.sv
// ============================================================================
// md_arith : combinational multiply/divide datapath, (op, a, b) -> {hi, lo, div0}
// Rev 1.0
// ============================================================================
`default_nettype none

module md_arith
   import md_pkg::*;
#(
   parameter int W = 32
) (
   input  md_op_t       op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] hi_n,
   output logic [W-1:0] lo_n,
   output logic         div0
);

   logic           signed_op;
   logic           neg_a;
   logic           neg_b;
   logic [2*W-1:0] mul_a;
   logic [2*W-1:0] mul_b;
   logic [2*W-1:0] prod;
   logic [W-1:0]   a_mag;
   logic [W-1:0]   b_mag;
   logic [W-1:0]   b_safe;
   logic [W-1:0]   q_mag;
   logic [W-1:0]   r_mag;

   always_comb begin
      signed_op = (op == MD_MULT) || (op == MD_DIV);
      neg_a     = signed_op && a[W-1];
      neg_b     = signed_op && b[W-1];

      // Low 2W bits of the extended product equal the true signed/unsigned product.
      mul_a = {{W{neg_a}}, a};
      mul_b = {{W{neg_b}}, b};
      prod  = mul_a * mul_b;

      // Divide on magnitudes so the most-negative dividend needs no special case.
      a_mag  = neg_a ? -a : a;
      b_mag  = neg_b ? -b : b;
      div0   = is_div(op) && (b == '0);
      b_safe = (b == '0) ? W'(1) : b_mag;
      q_mag  = a_mag / b_safe;
      r_mag  = a_mag % b_safe;

      hi_n = prod[2*W-1:W];
      lo_n = prod[W-1:0];
      if (is_div(op)) begin
         lo_n = (neg_a ^ neg_b) ? -q_mag : q_mag;
         hi_n = neg_a ? -r_mag : r_mag;
      end
   end

endmodule

`default_nettype wire

// File: rtl/md_sequencer.sv
// ============================================================================
// md_sequencer : multi-cycle MULT/DIV unit holding the architectural HI/LO
// Rev 1.0
// ============================================================================
`default_nettype none

module md_sequencer
   import md_pkg::*;
#(
   parameter int W           = 32,
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [2:0]   mdctr,
   input  logic         hiwrite,
   input  logic         lowrite,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] hi,
   output logic [W-1:0] lo
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);
   localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
   localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

   md_state_t    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   md_op_t       op_q, op_d;
   logic [W-1:0] a_q, a_d;
   logic [W-1:0] b_q, b_d;
   logic [W-1:0] hi_q, hi_d;
   logic [W-1:0] lo_q, lo_d;
   logic         done_q, done_d;

   md_op_t       op_in;
   logic         start_ok;
   logic [W-1:0] hi_n;
   logic [W-1:0] lo_n;
   logic         div0;

   assign op_in    = md_op_t'(mdctr[1:0]);
   assign start_ok = start && !mdctr[2];

   md_arith #(.W(W)) u_arith (
      .op   (op_q),
      .a    (a_q),
      .b    (b_q),
      .hi_n (hi_n),
      .lo_n (lo_n),
      .div0 (div0)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;

      unique case (state_q)
         IDLE: begin
            // A valid start takes priority over a same-cycle mthi/mtlo.
            if (start_ok) begin
               op_d    = op_in;
               a_d     = a;
               b_d     = b;
               cnt_d   = is_div(op_in) ? DIV_LOAD : MULT_LOAD;
               state_d = RUN;
            end else begin
               if (hiwrite) hi_d = a;
               if (lowrite) lo_d = a;
            end
         end
         RUN: begin
            if (cnt_q == '0) begin
               state_d = IDLE;
               done_d  = 1'b1;
               if (!div0) begin
                  hi_d = hi_n;
                  lo_d = lo_n;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_q    <= MD_MULT;
         a_q     <= '0;
         b_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end

   assign busy = (state_q == RUN);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_md_sequencer.sv
// ============================================================================
// tb_md_sequencer : directed scoreboard bench for md_sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_md_sequencer;
   import md_pkg::*;

   logic        clk;
   logic        rst;
   logic        start;
   logic [2:0]  mdctr;
   logic        hiwrite;
   logic        lowrite;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int          n_vec = 0;
   int          n_err = 0;
   logic [63:0] exp_q[$];
   logic [63:0] mon_e;

   md_sequencer #(.W(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .mdctr   (mdctr),
      .hiwrite (hiwrite),
      .lowrite (lowrite),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .hi      (hi),
      .lo      (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst && done) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_done: got done=1 required no pending op");
         end else begin
            mon_e = exp_q.pop_front();
            check("result_hi", hi, mon_e[63:32]);
            check("result_lo", lo, mon_e[31:0]);
            check("busy_at_done", {31'b0, busy}, 32'd0);
         end
      end
   end

   // Called at a negedge: present a start and queue its expected HI/LO.
   task automatic launch(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                         input logic hw, input logic lw, input logic [31:0] eh, input logic [31:0] el);
      start   = 1'b1;
      mdctr   = op;
      a       = av;
      b       = bv;
      hiwrite = hw;
      lowrite = lw;
      exp_q.push_back({eh, el});
   endtask

   // Count busy cycles after a launch; optionally fire a start on busy cycle 'intr'.
   task automatic run(input int n_exp, input int intr, input string name);
      int n;
      @(negedge clk);
      start   = 1'b0;
      hiwrite = 1'b0;
      lowrite = 1'b0;
      a       = $urandom;
      b       = $urandom;
      n = 0;
      while (busy && n < 60) begin
         n++;
         if (n == intr) begin
            start = 1'b1;
            mdctr = 3'd3;
            a     = 32'd9;
            b     = 32'd2;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
      check({name, "_busy_cycles"}, n, n_exp);
      check({name, "_done"}, {31'b0, done}, 32'd1);
   endtask

   task automatic mt(input logic hw, input logic lw, input logic [31:0] v);
      @(negedge clk);
      hiwrite = hw;
      lowrite = lw;
      a       = v;
      @(negedge clk);
      hiwrite = 1'b0;
      lowrite = 1'b0;
      check("mt_busy", {31'b0, busy}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int dones;
      rst = 1'b0; start = 1'b0; mdctr = 3'd0; hiwrite = 1'b0; lowrite = 1'b0;
      a = 32'd0; b = 32'd0;
      repeat (3) @(negedge clk);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_done", {31'b0, done}, 32'd0);
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);
      rst = 1'b1;

      @(negedge clk); launch(3'd0, 32'hFFFF_FFFD, 32'd7, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFEB); run(5, 0, "mult_neg");
      @(negedge clk); launch(3'd3, 32'd100, 32'd7, 0, 0, 32'd2, 32'd14); run(10, 0, "divu");
      @(negedge clk); launch(3'd2, 32'hFFFF_FFF9, 32'd2, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD); run(10, 0, "div_negdvd");
      @(negedge clk); launch(3'd2, 32'd7, 32'hFFFF_FFFE, 0, 0, 32'd1, 32'hFFFF_FFFD); run(10, 0, "div_negdvs");
      @(negedge clk); launch(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 32'd0, 32'h8000_0000); run(10, 0, "div_ovf");
      @(negedge clk); launch(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 32'd0, 32'd1); run(5, 0, "mult_m1sq");

      mt(1, 0, 32'h11);
      mt(0, 1, 32'h22);
      check("mthi", hi, 32'h11);
      check("mtlo", lo, 32'h22);
      @(negedge clk); launch(3'd2, 32'd5, 32'd0, 0, 0, 32'h11, 32'h22); run(10, 0, "div0");
      @(negedge clk); launch(3'd3, 32'd5, 32'd0, 0, 0, 32'h11, 32'h22); run(10, 0, "divu0");

      @(negedge clk); launch(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 32'hFFFF_FFFE, 32'd1); run(5, 2, "multu_intr");

      @(negedge clk); launch(3'd0, 32'd2, 32'd3, 0, 0, 32'd0, 32'd6); run(5, 0, "b2b_first");
      launch(3'd3, 32'd9, 32'd2, 0, 0, 32'd1, 32'd4); run(10, 0, "b2b_second");

      @(negedge clk); start = 1'b1; mdctr = 3'd5; a = 32'd1; b = 32'd1;
      @(negedge clk); start = 1'b0;
      check("reserved_busy", {31'b0, busy}, 32'd0);
      @(negedge clk);
      check("reserved_hi", hi, 32'd1);
      check("reserved_lo", lo, 32'd4);

      mt(0, 1, 32'h5);
      check("mtlo_idle", lo, 32'h5);
      mt(1, 1, 32'h77);
      check("mtboth_hi", hi, 32'h77);
      check("mtboth_lo", lo, 32'h77);
      mt(0, 1, 32'h5);
      @(negedge clk); launch(3'd2, 32'h99, 32'd0, 1, 1, 32'h77, 32'h5); run(10, 0, "start_wins");
      @(negedge clk); launch(3'd0, 32'd2, 32'd3, 1, 0, 32'd0, 32'd6); run(5, 0, "start_hw");

      @(negedge clk); start = 1'b1; mdctr = 3'd0; a = 32'd4; b = 32'd5;
      @(negedge clk); start = 1'b0;
      repeat (2) @(negedge clk);
      #1 rst = 1'b0;
      #1;
      check("midrst_busy", {31'b0, busy}, 32'd0);
      check("midrst_hi", hi, 32'd0);
      check("midrst_lo", lo, 32'd0);
      @(negedge clk); rst = 1'b1;
      dones = 0;
      repeat (8) begin
         @(negedge clk);
         if (done) dones++;
      end
      check("midrst_no_done", dones, 32'd0);
      @(negedge clk); launch(3'd0, 32'd2, 32'd3, 0, 0, 32'd0, 32'd6); run(5, 0, "post_rst");

      repeat (2) @(negedge clk);
      check("pending_ops", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
